// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 lane demultiplexer.
// Holds the lane codes, which double as the steered-mode controlInput codes,
// and the striping FSM state encoding.
package demux_pkg;

    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2,
        LANE_D = 2'd3
    } demux_lane_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } demux_state_e;

    // Round-robin successor: A->B->C->D->A.
    function automatic demux_lane_e next_lane(input demux_lane_e lane);
        return demux_lane_e'(2'(lane + 2'd1));
    endfunction

    // One-hot lane strobe, bit 0 = lane A.
    function automatic logic [3:0] lane_onehot(input demux_lane_e lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/demux_lanes_if.sv
// Bus bundle between the byte source / lane consumers and demux_lanes.
// Optional macro DEMUX_PARITY_EN adds inputParity and parityError.
//
// Handshake: there is no backpressure. inputValid=1 means inputData is
// consumed at the next rising clock edge, unconditionally. On the output
// side validA..D is a one-cycle strobe saying that lane register was
// written at the previous edge; consumers must capture it in that cycle.
interface demux_lanes_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0]        inputData;
    logic                     inputValid;
    logic                     controlMode;
    logic [1:0]               controlInput;
    logic [DATA_W-1:0]        outputA;
    logic [DATA_W-1:0]        outputB;
    logic [DATA_W-1:0]        outputC;
    logic [DATA_W-1:0]        outputD;
    logic                     validA;
    logic                     validB;
    logic                     validC;
    logic                     validD;
    logic [CNT_W-1:0]         roundCount;
    logic                     busy;
    demux_pkg::demux_state_e  dbg_state;
`ifdef DEMUX_PARITY_EN
    logic                     inputParity;
    logic                     parityError;

    modport master (
        output inputData, inputValid, controlMode, controlInput, inputParity,
        input  outputA, outputB, outputC, outputD,
        input  validA, validB, validC, validD,
        input  roundCount, busy, dbg_state, parityError
    );

    modport slave (
        input  inputData, inputValid, controlMode, controlInput, inputParity,
        output outputA, outputB, outputC, outputD,
        output validA, validB, validC, validD,
        output roundCount, busy, dbg_state, parityError
    );
`else
    modport master (
        output inputData, inputValid, controlMode, controlInput,
        input  outputA, outputB, outputC, outputD,
        input  validA, validB, validC, validD,
        input  roundCount, busy, dbg_state
    );

    modport slave (
        input  inputData, inputValid, controlMode, controlInput,
        output outputA, outputB, outputC, outputD,
        output validA, validB, validC, validD,
        output roundCount, busy, dbg_state
    );
`endif
endinterface

// File: rtl/demux_gap_timer.sv
// Idle-gap timer for the striping FSM.
// Counts tick cycles; expired is a combinational strobe on the tick that
// brings the count to GAP_LIMIT, so the caller can leave RUN on that same
// edge. The counter returns to zero on expiry or on clear.
module demux_gap_timer #(
    parameter int GAP_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int GW = (GAP_LIMIT < 1) ? 1 : $clog2(GAP_LIMIT + 1);
    localparam logic [GW-1:0] LAST = GW'(GAP_LIMIT - 1);

    logic [GW-1:0] cnt_q;

    assign expired = tick && !clear && (cnt_q == LAST);

    // Gap counter: clear wins over tick, wraps to zero on expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= expired ? '0 : cnt_q + GW'(1);
        end
    end
endmodule

// File: rtl/demux_lanes.sv
// Registered 1:4 byte demultiplexer (top).
// One byte stream is distributed onto lanes A..D, either steered by
// controlInput or striped round-robin by a two-state FSM. One cycle of
// latency, one-cycle per-lane valid strobe.
// Optional macro DEMUX_PARITY_EN adds a sticky even-parity error flag.
module demux_lanes
    import demux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int GAP_LIMIT = 4,
    parameter int CNT_W     = 8
) (
    input  logic          demuxCLK,
    input  logic          demuxRST,
    demux_lanes_if.slave  bus
);
    demux_state_e      state_q, state_d;
    demux_lane_e       ptr_q, ptr_d;
    demux_lane_e       lane_sel;
    logic              lane_we;
    logic              round_inc;
    logic              gap_clear;
    logic              gap_tick;
    logic              gap_expired;
    logic [DATA_W-1:0] lane_q [4];
    logic [3:0]        valid_q;
    logic [CNT_W-1:0]  round_q;

    demux_gap_timer #(
        .GAP_LIMIT (GAP_LIMIT)
    ) u_gap_timer (
        .clk     (demuxCLK),
        .rst     (demuxRST),
        .clear   (gap_clear),
        .tick    (gap_tick),
        .expired (gap_expired)
    );

    // Next state, lane steering and round/gap control.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lane_sel  = ptr_q;
        lane_we   = 1'b0;
        round_inc = 1'b0;
        gap_clear = 1'b0;
        gap_tick  = 1'b0;

        if (!bus.controlMode) begin
            // Steered mode always abandons any burst, so a later switch
            // back to striping restarts cleanly at lane A.
            state_d   = ST_IDLE;
            ptr_d     = LANE_A;
            gap_clear = 1'b1;
            if (bus.inputValid) begin
                lane_we  = 1'b1;
                lane_sel = demux_lane_e'(bus.controlInput);
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    gap_clear = 1'b1;
                    if (bus.inputValid) begin
                        lane_we  = 1'b1;
                        lane_sel = LANE_A;
                        ptr_d    = LANE_B;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.inputValid) begin
                        lane_we   = 1'b1;
                        lane_sel  = ptr_q;
                        ptr_d     = next_lane(ptr_q);
                        gap_clear = 1'b1;
                        round_inc = (ptr_q == LANE_D);
                    end else begin
                        gap_tick = 1'b1;
                        if (gap_expired) begin
                            // Partial round is dropped; roundCount holds.
                            state_d = ST_IDLE;
                            ptr_d   = LANE_A;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ptr_d   = LANE_A;
                end
            endcase
        end
    end

    // FSM state and lane pointer registers.
    always_ff @(posedge demuxCLK or posedge demuxRST) begin
        if (demuxRST) begin
            state_q <= ST_IDLE;
            ptr_q   <= LANE_A;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Lane data registers (hold when not written) and one-hot valid strobes.
    always_ff @(posedge demuxCLK or posedge demuxRST) begin
        if (demuxRST) begin
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            valid_q <= lane_we ? lane_onehot(lane_sel) : 4'b0000;
            if (lane_we) begin
                lane_q[lane_sel] <= bus.inputData;
            end
        end
    end

    // Completed stripe rounds, wrapping modulo 2^CNT_W.
    always_ff @(posedge demuxCLK or posedge demuxRST) begin
        if (demuxRST) begin
            round_q <= '0;
        end else if (round_inc) begin
            round_q <= round_q + CNT_W'(1);
        end
    end

`ifdef DEMUX_PARITY_EN
    logic parity_err_q;

    // Sticky even-parity error over every accepted byte.
    always_ff @(posedge demuxCLK or posedge demuxRST) begin
        if (demuxRST) begin
            parity_err_q <= 1'b0;
        end else if (bus.inputValid && ((^bus.inputData) != bus.inputParity)) begin
            parity_err_q <= 1'b1;
        end
    end

    assign bus.parityError = parity_err_q;
`endif

    assign bus.outputA    = lane_q[0];
    assign bus.outputB    = lane_q[1];
    assign bus.outputC    = lane_q[2];
    assign bus.outputD    = lane_q[3];
    assign bus.validA     = valid_q[0];
    assign bus.validB     = valid_q[1];
    assign bus.validC     = valid_q[2];
    assign bus.validD     = valid_q[3];
    assign bus.roundCount = round_q;
    assign bus.busy       = (state_q == ST_RUN);
    assign bus.dbg_state  = state_q;
endmodule
